nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Multi-precision add/subtract sequencer built around one shared 4-bit adder slice (A, B, carry-in -> 4-bit sum, carry-out).
- Latches two operands of 4*WORDS bits and feeds the slice one nibble per clock, LSB nibble first.
- Chains the carry through a register between nibbles.
- Publishes the full-width result with a one-cycle Done pulse.
- Lets wide arithmetic reuse the small ripple slice instead of a full-width adder.

Parameters:
WORDS, 4, number of 4-bit nibbles per operand (operand width = 4*WORDS); legal range 1..16.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Start  input  1  request; accepted on a rising edge where Start=1 and Ready=1
Subtract  input  1  sampled with Start; 1 = A - B - InputCarry (borrow-in), 0 = A + B + InputCarry
InputA  input  4*WORDS  operand A, sampled on accept
InputB  input  4*WORDS  operand B, sampled on accept
InputCarry  input  1  carry-in (add) or borrow-in (subtract), sampled on accept
Ready  output  1  block can accept Start this cycle
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse: result valid
Output  output  4*WORDS  result; holds until the next Done
OutputCarry  output  1  final carry-out (subtract: 1 = no borrow)
Overflow  output  1  two's-complement signed overflow of the full-width result

Behaviour:
- Reset (Reset=1 at an edge):
  - State goes to IDLE; nibble index, carry and operand registers are cleared.
  - Output=0, OutputCarry=0, Overflow=0, Done=0, Busy=0, Ready=1 from the next cycle.
  - Reset has priority over everything, including Start.
- States:
  - IDLE: Ready=1, Busy=0, Done=0.
  - RUN: Ready=0, Busy=1, Done=0.
  - DONE: Ready=1, Busy=0, Done=1. Lasts exactly one cycle.
- Accept: at an edge in IDLE or DONE with Start=1:
  - Latch A = InputA.
  - Latch B' = Subtract ? ~InputB : InputB.
  - Latch carry = InputCarry XOR Subtract.
  - Index = 0; go to RUN.
  - In DONE, Start=0 goes to IDLE.
- RUN, each edge:
  - Slice computes A[idx], B'[idx], carry -> sum, cout.
  - sum is written into the internal result accumulator at nibble idx; carry <= cout; idx++.
  - On the edge where idx = WORDS-1: copy the accumulator (with this nibble) to Output, set OutputCarry=cout, set Overflow, go to DONE.
- Overflow = (A msb == B' msb) AND (result msb != A msb), using the effective (possibly inverted) B.
- Latency: accept edge at t. Done=1 during cycle t+WORDS. Back-to-back issue gives one result per WORDS+1 cycles.
- Start while Busy=1 is ignored; no queueing, no error flag. Operand inputs may change freely after accept.
- Output, OutputCarry and Overflow never show partial results. They change only on the edge entering DONE (or on reset).
- WORDS=1: RUN lasts one cycle; Done comes 1 cycle after accept.
- Reset mid-RUN aborts: no Done pulse; outputs are cleared per reset rule.
- No combinational path from Start to Ready/Busy/Done. All outputs are registered or decoded from state only.

Test Plan:
(WORDS=4; t = accept edge)
1. Add, no carry: A=0x1234, B=0x0FCC, Subtract=0, InputCarry=0 -> in cycle t+4: Done=1, Output=0x2200, OutputCarry=0, Overflow=0. Done=0 at t+5.
2. Carry wrap: A=0xFFFF, B=0x0001, Cin=0 -> Output=0x0000, OutputCarry=1, Overflow=0. Separately, A=0x7FFF, B=0x0001 -> Output=0x8000, OutputCarry=0, Overflow=1.
3. Subtract:
   - A=0x0005, B=0x0007, Subtract=1, Cin=0 -> Output=0xFFFE, OutputCarry=0 (borrow), Overflow=0.
   - A=0x8000, B=0x0001, Subtract=1 -> Output=0x7FFF, OutputCarry=1, Overflow=1.
   - A=0x0010, B=0x0001, Subtract=1, Cin=1 -> Output=0x000E.
4. Handshake:
   - Start held high with new operands through RUN -> ignored; Output stays at the previous result until Done.
   - Start=1 in the DONE cycle with A=0x0001, B=0x0002 -> accepted; next Done at t'+4 with Output=0x0003. Done is never high for two consecutive cycles.
5. Reset mid-operation: accept A=0x1111, B=0x2222; assert Reset at t+2 -> next cycle Busy=0, Ready=1, Output=0. No Done pulse within 10 cycles. A subsequent op completes normally.
6. Parameter sweep: WORDS=1, A=0xF, B=0x1 -> Done at t+1, Output=0x0, OutputCarry=1. Also random checks against the reference model for WORDS=1, 4 and 8.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - multi-precision add/subtract sequencer over a shared 4-bit adder slice
//
// Purpose: latches two 4*WORDS-bit operands and walks them through a single
// 4-bit adder slice, one nibble per clock (LSB nibble first), chaining the
// carry through a register. The full-width result is published together with
// a one-cycle Done pulse.
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous, active-high reset
//   Start        request, accepted when Ready=1
//   Subtract     1 = A - B - InputCarry, 0 = A + B + InputCarry (sampled on accept)
//   InputA       operand A (sampled on accept)
//   InputB       operand B (sampled on accept)
//   InputCarry   carry-in / borrow-in (sampled on accept)
//   Ready        block can accept Start this cycle
//   Busy         operation in progress
//   Done         one-cycle pulse, result valid
//   Output       result, held until the next Done
//   OutputCarry  final carry-out (subtract: 1 = no borrow)
//   Overflow     two's-complement signed overflow of the full-width result

// 4-bit ripple slice shared by every nibble of the operation.
module nibbleAdderSlice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carryIn,
    output logic [3:0] sum,
    output logic       carryOut
);
    assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, carryIn};
endmodule

module nibble_serial_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Subtract,
    input  logic [4*WORDS-1:0]   InputA,
    input  logic [4*WORDS-1:0]   InputB,
    input  logic                 InputCarry,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Done,
    output logic [4*WORDS-1:0]   Output,
    output logic                 OutputCarry,
    output logic                 Overflow
);
    localparam int WIDTH = 4 * WORDS;
    // A one-nibble operand still needs a 1-bit index register.
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] lastIndex = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } stateType;

    stateType           state;
    logic [IDXW-1:0]    nibbleIndex;
    logic               carry;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;      // already inverted for subtract
    logic [WIDTH-1:0]   acc;

    logic [3:0]         sliceA;
    logic [3:0]         sliceB;
    logic [3:0]         sliceSum;
    logic               sliceCarry;
    logic [WIDTH-1:0]   nextAcc;

    // Nibble select and accumulator merge use constant part-selects so no
    // out-of-range index can be formed for any WORDS value.
    always_comb begin
        sliceA = 4'h0;
        sliceB = 4'h0;
        for (int i = 0; i < WORDS; i++) begin
            if (nibbleIndex == IDXW'(i)) begin
                sliceA = opA[i*4 +: 4];
                sliceB = opB[i*4 +: 4];
            end
        end
    end

    nibbleAdderSlice slice (
        .a        (sliceA),
        .b        (sliceB),
        .carryIn  (carry),
        .sum      (sliceSum),
        .carryOut (sliceCarry)
    );

    always_comb begin
        nextAcc = acc;
        for (int i = 0; i < WORDS; i++) begin
            if (nibbleIndex == IDXW'(i)) begin
                nextAcc[i*4 +: 4] = sliceSum;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= StIdle;
            nibbleIndex <= '0;
            carry       <= 1'b0;
            opA         <= '0;
            opB         <= '0;
            acc         <= '0;
            Output      <= '0;
            OutputCarry <= 1'b0;
            Overflow    <= 1'b0;
            Ready       <= 1'b1;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    Done <= 1'b0;
                    if (Start) begin
                        // Subtract is A + ~B + 1 with the borrow-in folded into the carry.
                        opA         <= InputA;
                        opB         <= Subtract ? ~InputB : InputB;
                        carry       <= InputCarry ^ Subtract;
                        nibbleIndex <= '0;
                        acc         <= '0;
                        state       <= StRun;
                        Ready       <= 1'b0;
                        Busy        <= 1'b1;
                    end else begin
                        state <= StIdle;
                        Ready <= 1'b1;
                        Busy  <= 1'b0;
                    end
                end
                StRun: begin
                    acc         <= nextAcc;
                    carry       <= sliceCarry;
                    nibbleIndex <= nibbleIndex + 1'b1;
                    if (nibbleIndex == lastIndex) begin
                        Output      <= nextAcc;
                        OutputCarry <= sliceCarry;
                        // Signed overflow uses the effective (possibly inverted) B.
                        Overflow    <= (opA[WIDTH-1] == opB[WIDTH-1]) &&
                                       (nextAcc[WIDTH-1] != opA[WIDTH-1]);
                        state       <= StDone;
                        Ready       <= 1'b1;
                        Busy        <= 1'b0;
                        Done        <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    Ready <= 1'b1;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed and model-based checks of nibble_serial_add_ctrl for WORDS=1,4,8

module tb_nibble_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic        start8 = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;

    logic        rdy1, bsy1, dn1, oc1, ov1;
    logic [3:0]  out1;
    logic        rdy4, bsy4, dn4, oc4, ov4;
    logic [15:0] out4;
    logic        rdy8, bsy8, dn8, oc8, ov8;
    logic [31:0] out8;

    int errors = 0;
    int checks = 0;
    int curSel = 4;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WORDS(1)) dut1 (
        .Clock(clk), .Reset(rst), .Start(start1), .Subtract(sub),
        .InputA(opA[3:0]), .InputB(opB[3:0]), .InputCarry(cin),
        .Ready(rdy1), .Busy(bsy1), .Done(dn1), .Output(out1),
        .OutputCarry(oc1), .Overflow(ov1)
    );

    nibble_serial_add_ctrl #(.WORDS(4)) dut4 (
        .Clock(clk), .Reset(rst), .Start(start4), .Subtract(sub),
        .InputA(opA[15:0]), .InputB(opB[15:0]), .InputCarry(cin),
        .Ready(rdy4), .Busy(bsy4), .Done(dn4), .Output(out4),
        .OutputCarry(oc4), .Overflow(ov4)
    );

    nibble_serial_add_ctrl #(.WORDS(8)) dut8 (
        .Clock(clk), .Reset(rst), .Start(start8), .Subtract(sub),
        .InputA(opA), .InputB(opB), .InputCarry(cin),
        .Ready(rdy8), .Busy(bsy8), .Done(dn8), .Output(out8),
        .OutputCarry(oc8), .Overflow(ov8)
    );

    logic        selBsy, selDn, selOc, selOv;
    logic [31:0] selOut;

    always_comb begin
        selBsy = bsy4;
        selDn  = dn4;
        selOc  = oc4;
        selOv  = ov4;
        selOut = {16'h0000, out4};
        case (curSel)
            1: begin
                selBsy = bsy1; selDn = dn1; selOc = oc1; selOv = ov1;
                selOut = {28'h0, out1};
            end
            8: begin
                selBsy = bsy8; selDn = dn8; selOc = oc8; selOv = ov8;
                selOut = out8;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setStart(input int w, input logic v);
        case (w)
            1:       start1 = v;
            8:       start8 = v;
            default: start4 = v;
        endcase
    endtask

    task automatic doOp(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c,
                        output logic [31:0] o, output logic oc, output logic ov);
        int lat;
        curSel = w;
        @(negedge clk);
        opA = a; opB = b; sub = s; cin = c;
        setStart(w, 1'b1);
        @(negedge clk);
        setStart(w, 1'b0);
        check("busy_after_accept", {31'b0, selBsy}, 32'd1);
        lat = 0;
        while (!selDn && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, w);
        o  = selOut;
        oc = selOc;
        ov = selOv;
        @(negedge clk);
        check("done_one_cycle", {31'b0, selDn}, 32'd0);
    endtask

    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic c);
        logic [31:0] mask, aM, bEff, res;
        logic [32:0] full;
        logic        carryOut, ovf;
        int          msb;
        mask = (w == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * w)) - 32'h1);
        aM   = a & mask;
        bEff = (s ? ~b : b) & mask;
        full = {1'b0, aM} + {1'b0, bEff} + {32'h0, c ^ s};
        res  = full[31:0] & mask;
        carryOut = full[4 * w];
        msb  = 4 * w - 1;
        ovf  = (aM[msb] == bEff[msb]) && (res[msb] != aM[msb]);
        return {ovf, carryOut, res};
    endfunction

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        c;
        logic [31:0] eo;
        logic        ec;
        logic        ev;
    } vecType;

    vecType vecs[8];

    initial begin
        logic [31:0] o;
        logic        oc, ov;
        logic [33:0] exp;
        int          lat;
        logic        flag;
        int          widths[3];

        vecs[0] = '{4, 32'h1234, 32'h0FCC, 1'b0, 1'b0, 32'h2200, 1'b0, 1'b0};
        vecs[1] = '{4, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0};
        vecs[2] = '{4, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1};
        vecs[3] = '{4, 32'h0005, 32'h0007, 1'b1, 1'b0, 32'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{4, 32'h8000, 32'h0001, 1'b1, 1'b0, 32'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{4, 32'h0010, 32'h0001, 1'b1, 1'b1, 32'h000E, 1'b1, 1'b0};
        vecs[6] = '{1, 32'hF,    32'h1,    1'b0, 1'b0, 32'h0,    1'b1, 1'b0};
        vecs[7] = '{8, 32'h89AB_CDEF, 32'h7654_3211, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, rdy4}, 32'd1);
        check("rst_busy",  {31'b0, bsy4}, 32'd0);
        check("rst_done",  {31'b0, dn4},  32'd0);
        check("rst_out",   {16'h0, out4}, 32'h0);
        check("rst_carry", {30'b0, oc4, ov4}, 32'd0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            doOp(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, o, oc, ov);
            check($sformatf("vec%0d_out", i), o, vecs[i].eo);
            check($sformatf("vec%0d_carry", i), {31'b0, oc}, {31'b0, vecs[i].ec});
            check($sformatf("vec%0d_ovf", i), {31'b0, ov}, {31'b0, vecs[i].ev});
        end

        // Start held through RUN is ignored; Start in the DONE cycle is accepted
        curSel = 4;
        @(negedge clk);
        opA = 32'h0100; opB = 32'h0200; sub = 1'b0; cin = 1'b0; start4 = 1'b1;
        @(negedge clk);
        opA = 32'hAAAA; opB = 32'h5555;
        check("hs_busy", {31'b0, bsy4}, 32'd1);
        check("hs_hold_first", {16'h0, out4}, 32'h000E);
        lat = 0;
        flag = 1'b0;
        while (!dn4 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!dn4 && out4 !== 16'h000E) flag = 1'b1;
        end
        check("hs_latency", lat, 32'd4);
        check("hs_no_partial", {31'b0, flag}, 32'd0);
        check("hs_out", {16'h0, out4}, 32'h0300);
        opA = 32'h0001; opB = 32'h0002;
        @(negedge clk);
        start4 = 1'b0;
        check("hs_no_double_done", {31'b0, dn4}, 32'd0);
        check("hs_busy_again", {31'b0, bsy4}, 32'd1);
        lat = 0;
        while (!dn4 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hs_latency2", lat, 32'd4);
        check("hs_out2", {16'h0, out4}, 32'h0003);

        // Reset mid-operation
        @(negedge clk);
        opA = 32'h1111; opB = 32'h2222; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",  {31'b0, bsy4}, 32'd0);
        check("abort_ready", {31'b0, rdy4}, 32'd1);
        check("abort_out",   {16'h0, out4}, 32'h0);
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (dn4) flag = 1'b1;
        end
        check("abort_no_done", {31'b0, flag}, 32'd0);
        doOp(4, 32'h1234, 32'h0FCC, 1'b0, 1'b0, o, oc, ov);
        check("after_abort_out", o, 32'h2200);

        // Random operands against the full-width model
        widths[0] = 1; widths[1] = 4; widths[2] = 8;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 6; j++) begin
                logic [31:0] ra, rb;
                logic        rs, rc;
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom_range(0, 1));
                rc = 1'($urandom_range(0, 1));
                exp = model(widths[k], ra, rb, rs, rc);
                doOp(widths[k], ra, rb, rs, rc, o, oc, ov);
                check($sformatf("rnd_w%0d_out", widths[k]), o, exp[31:0]);
                check($sformatf("rnd_w%0d_carry", widths[k]), {31'b0, oc}, {31'b0, exp[32]});
                check($sformatf("rnd_w%0d_ovf", widths[k]), {31'b0, ov}, {31'b0, exp[33]});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
